// File: rtl/mmt_result_packer.sv
// Buffers single-cycle signed engine results in a small FIFO and re-emits each one
// as a sign-extended, LSB-first byte burst over a ready/valid byte channel.
module mmt_result_packer #(
    parameter int IN_W   = 50,
    parameter int OUT_W  = 8,
    parameter int DEPTH  = 4,
    parameter int NBYTES = 7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [IN_W-1:0]            in_value,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [OUT_W-1:0]           out_byte,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     fifo_cnt,
    output logic [7:0]                 drop_cnt
);

    localparam int WW    = NBYTES * OUT_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam int BW    = $clog2(NBYTES);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [BW-1:0] LAST_IDX = BW'(NBYTES - 1);

    typedef enum logic {EMPTY, SEND} state_t;

    state_t           state;
    logic [WW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic [BW-1:0]    bidx;
    logic [WW-1:0]    ext_word;
    logic [OUT_W-1:0] head_bytes [NBYTES];
    logic             xfer;
    logic             pop;
    logic             push;
    logic             drop;

    assign ext_word = {{(WW - IN_W){in_value[IN_W-1]}}, in_value};

    // A full FIFO still accepts a result when the head is popped on the same edge.
    always_comb begin
        xfer = (state == SEND) && out_ready;
        pop  = xfer && (bidx == LAST_IDX);
        push = in_valid && !flush && ((count != FULL) || pop);
        drop = in_valid && !flush && (count == FULL) && !pop;
        count_next = count;
        if (push && !pop)
            count_next = count + CW'(1);
        else if (pop && !push)
            count_next = count - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            bidx     <= '0;
            drop_cnt <= '0;
        end else if (flush) begin
            state  <= EMPTY;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            bidx   <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                bidx   <= '0;
            end else if (xfer) begin
                bidx <= bidx + BW'(1);
            end
            count <= count_next;
            state <= (count_next == '0) ? EMPTY : SEND;
            if (drop && (drop_cnt != 8'hFF))
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= ext_word;
    end

    always_comb begin
        for (int i = 0; i < NBYTES; i++)
            head_bytes[i] = mem[rd_ptr][i*OUT_W +: OUT_W];
    end

    assign out_valid = (state == SEND);
    assign out_byte  = (state == SEND) ? head_bytes[bidx] : '0;
    assign out_last  = (state == SEND) && (bidx == LAST_IDX);
    assign fifo_cnt  = count;

endmodule

// File: tb/tb_mmt_result_packer.sv
// Directed bench for mmt_result_packer: vector table for the basic bursts plus
// hand-written sequences for back-pressure, full-FIFO, flush and reset corners.
module tb_mmt_result_packer;

    localparam int IN_W   = 50;
    localparam int OUT_W  = 8;
    localparam int DEPTH  = 4;
    localparam int NBYTES = 7;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [IN_W-1:0]  in_value = '0;
    logic             flush = 1'b0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [OUT_W-1:0] out_byte;
    logic             out_last;
    logic [2:0]       fifo_cnt;
    logic [7:0]       drop_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic            iv;
        logic [IN_W-1:0] v;
        logic            rdy;
        logic            fl;
        logic            ev;
        logic [7:0]      eb;
        logic            el;
        logic [2:0]      ec;
        logic [7:0]      ed;
    } vec_t;

    vec_t            vecs[$];
    logic [IN_W-1:0] pend[$];

    mmt_result_packer #(
        .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .NBYTES(NBYTES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_value(in_value),
        .flush(flush),
        .out_valid(out_valid),
        .out_byte(out_byte),
        .out_last(out_last),
        .out_ready(out_ready),
        .fifo_cnt(fifo_cnt),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [IN_W-1:0] v, input logic rdy, input logic fl);
        in_valid  = iv;
        in_value  = v;
        out_ready = rdy;
        flush     = fl;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic void addVec(input logic iv, input logic [IN_W-1:0] v, input logic rdy,
                                   input logic ev, input logic [7:0] eb, input logic el,
                                   input logic [2:0] ec, input logic [7:0] ed);
        vec_t t;
        t.iv = iv; t.v = v; t.rdy = rdy; t.fl = 1'b0;
        t.ev = ev; t.eb = eb; t.el = el; t.ec = ec; t.ed = ed;
        vecs.push_back(t);
    endfunction

    // Drains every queued result with ready held high, comparing against the sign-extended value.
    task automatic drainExpect(input string tag);
        logic [IN_W-1:0] v;
        logic [55:0]     w;
        int              waited;
        out_ready = 1'b1;
        while (pend.size() > 0) begin
            v = pend.pop_front();
            w = {{(56 - IN_W){v[IN_W-1]}}, v};
            for (int k = 0; k < NBYTES; k++) begin
                waited = 0;
                @(negedge clk);
                while (!out_valid && waited < 20) begin
                    @(negedge clk);
                    waited++;
                end
                if (!out_valid) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL %s timeout: out_valid=0 expected 1", tag);
                    pend.delete();
                    return;
                end
                checkOutput({tag, " byte"}, 64'(out_byte), 64'(w[8*k +: 8]));
                checkOutput({tag, " last"}, 64'(out_last), 64'(k == NBYTES - 1));
                nextCycle();
            end
        end
        @(negedge clk);
        checkOutput({tag, " idle valid"}, 64'(out_valid), 64'd0);
        checkOutput({tag, " idle cnt"}, 64'(fifo_cnt), 64'd0);
        nextCycle();
    endtask

    initial begin
        logic [7:0]      b1 [7];
        logic [IN_W-1:0] v5;
        int              sent;
        bit              flushed;

        b1 = '{8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};

        // Basic burst, then all-ones and most-negative values back to back.
        addVec(1'b1, 50'h0123456789ABCD, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 8'd0);
        for (int k = 0; k < 7; k++)
            addVec(1'b0, '0, 1'b1, 1'b1, b1[k], k == 6, 3'd1, 8'd0);
        addVec(1'b1, 50'h3FFFFFFFFFFFF, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 8'd0);
        addVec(1'b1, 50'h2000000000000, 1'b1, 1'b1, 8'hFF, 1'b0, 3'd1, 8'd0);
        for (int k = 1; k < 7; k++)
            addVec(1'b0, '0, 1'b1, 1'b1, 8'hFF, k == 6, 3'd2, 8'd0);
        for (int k = 0; k < 6; k++)
            addVec(1'b0, '0, 1'b1, 1'b1, 8'h00, 1'b0, 3'd1, 8'd0);
        addVec(1'b0, '0, 1'b1, 1'b1, 8'hFE, 1'b1, 3'd1, 8'd0);
        addVec(1'b0, '0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 8'd0);

        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset valid", 64'(out_valid), 64'd0);
        checkOutput("reset byte", 64'(out_byte), 64'd0);
        checkOutput("reset last", 64'(out_last), 64'd0);
        checkOutput("reset cnt", 64'(fifo_cnt), 64'd0);
        checkOutput("reset drop", 64'(drop_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] vector table: %0d entries", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].iv, vecs[i].v, vecs[i].rdy, vecs[i].fl);
            @(negedge clk);
            checkOutput($sformatf("vec%0d valid", i), 64'(out_valid), 64'(vecs[i].ev));
            checkOutput($sformatf("vec%0d byte", i), 64'(out_byte), 64'(vecs[i].eb));
            checkOutput($sformatf("vec%0d last", i), 64'(out_last), 64'(vecs[i].el));
            checkOutput($sformatf("vec%0d cnt", i), 64'(fifo_cnt), 64'(vecs[i].ec));
            checkOutput($sformatf("vec%0d drop", i), 64'(drop_cnt), 64'(vecs[i].ed));
            nextCycle();
        end

        // Back-pressure: five pulses into a four-entry FIFO.
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 50'(i), 1'b0, 1'b0);
            nextCycle();
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("stall cnt", 64'(fifo_cnt), 64'd4);
            checkOutput("stall drop", 64'(drop_cnt), 64'd1);
            checkOutput("stall valid", 64'(out_valid), 64'd1);
            checkOutput("stall byte", 64'(out_byte), 64'h01);
            checkOutput("stall last", 64'(out_last), 64'd0);
            nextCycle();
        end
        pend = '{50'd1, 50'd2, 50'd3, 50'd4};
        drainExpect("release");

        // Full FIFO with a push on the same edge as the head's last byte.
        for (int i = 10; i <= 13; i++) begin
            applyStimulus(1'b1, 50'(i), 1'b0, 1'b0);
            nextCycle();
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++)
            nextCycle();
        applyStimulus(1'b1, 50'd14, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("full last", 64'(out_last), 64'd1);
        checkOutput("full cnt before", 64'(fifo_cnt), 64'd4);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("full cnt after", 64'(fifo_cnt), 64'd4);
        checkOutput("full drop", 64'(drop_cnt), 64'd1);
        checkOutput("full head byte", 64'(out_byte), 64'h0B);
        nextCycle();
        pend = '{50'd11, 50'd12, 50'd13, 50'd14};
        drainExpect("full");

        // Random ready, then flush while byte 3 is presented (with a discarded push).
        v5 = 50'h2A5C3_9E17_4B08;
        applyStimulus(1'b1, v5, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        sent = 0;
        flushed = 1'b0;
        for (int c = 0; c < 200 && !flushed; c++) begin
            if (sent == 3) begin
                applyStimulus(1'b1, 50'h1234, 1'(($urandom % 2)), 1'b1);
                flushed = 1'b1;
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (flushed)
                checkOutput("flush byte3", 64'(out_byte), 64'(v5[31:24]));
            else if (out_valid && out_ready)
                sent++;
            nextCycle();
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        if (!flushed) begin
            total++;
            bad++;
            $display("[TB] FAIL flush timeout: sent=%0d expected 3", sent);
        end
        @(negedge clk);
        checkOutput("flush valid", 64'(out_valid), 64'd0);
        checkOutput("flush cnt", 64'(fifo_cnt), 64'd0);
        checkOutput("flush drop", 64'(drop_cnt), 64'd1);
        checkOutput("flush byte", 64'(out_byte), 64'd0);
        nextCycle();
        applyStimulus(1'b1, 50'h3_0000_0000_0081, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        pend = '{50'h3_0000_0000_0081};
        drainExpect("post flush");

        // Saturate the drop counter, then reset asynchronously mid-burst.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 50'(i + 1), 1'b0, 1'b0);
            nextCycle();
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("sat drop", 64'(drop_cnt), 64'd255);
        checkOutput("sat cnt", 64'(fifo_cnt), 64'd4);
        nextCycle();
        out_ready = 1'b1;
        repeat (3) nextCycle();
        out_ready = 1'b0;
        #1;
        checkOutput("midburst byte", 64'(out_byte), 64'd0);
        checkOutput("midburst valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async rst valid", 64'(out_valid), 64'd0);
        checkOutput("async rst byte", 64'(out_byte), 64'd0);
        checkOutput("async rst last", 64'(out_last), 64'd0);
        checkOutput("async rst cnt", 64'(fifo_cnt), 64'd0);
        checkOutput("async rst drop", 64'(drop_cnt), 64'd0);
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(1'b1, 50'h0777, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        pend = '{50'h0777};
        drainExpect("post reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
